// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, PCSource encodings and the fetch FSM state type.
package cpu_pkg;

  localparam logic [5:0] OP_HALT = 6'b010111;
  localparam logic [5:0] OP_JUMP = 6'b010010;
  localparam logic [5:0] OP_JR   = 6'b010011;

  localparam logic [1:0] PC_SEQ  = 2'b00;
  localparam logic [1:0] PC_JUMP = 2'b10;
  localparam logic [1:0] PC_JR   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_ISSUE,
    ST_HALTED
  } fetch_state_e;

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC select for the fetch stage: sequential, JUMP target or JR register, plus the pc+1 link value.
module fetch_next_pc
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic [ADDR_W-1:0] jr_target,
  input  logic [1:0]        pc_source,
  output logic [ADDR_W-1:0] next_pc,
  output logic [ADDR_W-1:0] pc_plus1
);

  // Width-limited add, so the last word wraps to address zero.
  assign pc_plus1 = pc + ADDR_W'(1);

  always_comb begin
    next_pc = pc_plus1;
    case (pc_source)
      PC_JUMP: next_pc = jump_target;
      PC_JR:   next_pc = jr_target;
      default: next_pc = pc_plus1;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, memory request FSM and instruction register feeding the decoder.
// Optional fetch-address bounds check is compiled in with `define FETCH_BOUNDS_EN.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W     = 10,
  parameter int                INSTR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                IMEM_DEPTH = 1024
) (
  input  logic               clock,
  input  logic               resetCPU_n,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic               imem_rd,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_valid,
  input  logic               stall,
  input  logic [1:0]         PCSource,
  input  logic [ADDR_W-1:0]  jr_target,
  input  logic               isHalt,
  output logic [INSTR_W-1:0] instr,
  output logic [5:0]         opcode,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W-1:0]  pc_plus1,
  output logic               halted
`ifdef FETCH_BOUNDS_EN
  , output logic             fetch_fault
`endif
);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               imem_rd_q, imem_rd_d;
  logic               instr_valid_q, instr_valid_d;
  logic               halted_q, halted_d;
  logic [ADDR_W-1:0]  next_pc;
  logic               halt_req;
  logic               pc_q_ok, pc_d_ok;

  fetch_next_pc #(.ADDR_W(ADDR_W)) u_next_pc (
    .pc          (pc_q),
    .jump_target (instr_q[ADDR_W-1:0]),
    .jr_target   (jr_target),
    .pc_source   (PCSource),
    .next_pc     (next_pc),
    .pc_plus1    (pc_plus1)
  );

`ifdef FETCH_BOUNDS_EN
  logic fault_q, fault_d;
  assign pc_q_ok     = {1'b0, pc_q} < (ADDR_W+1)'(IMEM_DEPTH);
  assign pc_d_ok     = {1'b0, pc_d} < (ADDR_W+1)'(IMEM_DEPTH);
  assign fetch_fault = fault_q;
`else
  logic unused_depth;
  assign unused_depth = ^IMEM_DEPTH;
  assign pc_q_ok      = 1'b1;
  assign pc_d_ok      = 1'b1;
`endif

  assign halt_req = (instr_q[31:26] == OP_HALT) || isHalt;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
`ifdef FETCH_BOUNDS_EN
    fault_d = fault_q;
`endif
    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        if (pc_q_ok) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_HALTED;
`ifdef FETCH_BOUNDS_EN
          fault_d = 1'b1;
`endif
        end
      end
      ST_WAIT: begin
        if (imem_valid) begin
          instr_d = imem_rdata;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // A stall holds the issue even when a halt is pending; the halt waits for release.
        if (!stall) begin
          if (halt_req) begin
            state_d = ST_HALTED;
          end else begin
            pc_d    = next_pc;
            state_d = ST_REQ;
          end
        end
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Registered strobes are decoded from the next state so they line up with it.
  assign imem_rd_d     = (state_d == ST_REQ) && pc_d_ok;
  assign instr_valid_d = (state_d == ST_ISSUE);
  assign halted_d      = (state_d == ST_HALTED);

  always_ff @(posedge clock or negedge resetCPU_n) begin
    if (!resetCPU_n) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      imem_rd_q     <= 1'b0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
`ifdef FETCH_BOUNDS_EN
      fault_q       <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so all flops update from the same pre-edge values.
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      imem_rd_q     <= imem_rd_d;
      instr_valid_q <= instr_valid_d;
      halted_q      <= halted_d;
`ifdef FETCH_BOUNDS_EN
      fault_q       <= fault_d;
`endif
    end
  end

  assign imem_addr   = pc_q;
  assign imem_rd     = imem_rd_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[31:26];
  assign instr_valid = instr_valid_q;
  assign pc          = pc_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: behavioural instruction memory with variable latency and
// a scoreboard of expected (pc, instr) issues popped whenever instr_valid is seen.
module tb_fetch_unit;
  import cpu_pkg::*;

  localparam int ADDR_W  = 10;
  localparam int INSTR_W = 32;
`ifdef FETCH_BOUNDS_EN
  localparam int DEPTH = 16;
`else
  localparam int DEPTH = 1024;
`endif

  logic               clock = 1'b0;
  logic               resetCPU_n = 1'b0;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_rd;
  logic [INSTR_W-1:0] imem_rdata = '0;
  logic               imem_valid = 1'b0;
  logic               stall = 1'b0;
  logic [1:0]         PCSource = PC_SEQ;
  logic [ADDR_W-1:0]  jr_target = '0;
  logic               isHalt = 1'b0;
  logic [INSTR_W-1:0] instr;
  logic [5:0]         opcode;
  logic               instr_valid;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  pc_plus1;
  logic               halted;
`ifdef FETCH_BOUNDS_EN
  logic               fetch_fault;
`endif

  always #5 clock = ~clock;

  fetch_unit #(
    .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RESET_PC('0), .IMEM_DEPTH(DEPTH)
  ) dut (
    .clock(clock), .resetCPU_n(resetCPU_n), .imem_addr(imem_addr), .imem_rd(imem_rd),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid), .stall(stall), .PCSource(PCSource),
    .jr_target(jr_target), .isHalt(isHalt), .instr(instr), .opcode(opcode),
    .instr_valid(instr_valid), .pc(pc), .pc_plus1(pc_plus1), .halted(halted)
`ifdef FETCH_BOUNDS_EN
    , .fetch_fault(fetch_fault)
`endif
  );

  // Instruction memory: a read seen at a negedge returns data lat negedges later.
  logic [31:0]       mem [1024];
  int                lat = 1;
  int                cnt = 0;
  int                rd_count = 0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic              inject = 1'b0;
  logic [31:0]       inject_data = '0;

  always @(negedge clock) begin
    if (!resetCPU_n) cnt = 0;
    imem_valid = 1'b0;
    imem_rdata = 'x;
    if (inject) begin
      imem_valid = 1'b1;
      imem_rdata = inject_data;
    end else if (cnt == 1) begin
      imem_valid = 1'b1;
      imem_rdata = mem[rd_addr];
    end
    if (cnt > 0) cnt = cnt - 1;
    if (imem_rd && resetCPU_n) begin
      rd_addr  = imem_addr;
      cnt      = lat;
      rd_count = rd_count + 1;
    end
  end

  typedef struct {
    logic [ADDR_W-1:0] pc;
    logic [31:0]       instr;
  } exp_t;
  exp_t sb[$];

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;
  int cyc = 0;
  int last_issue = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic push(input int a);
    exp_t e;
    e.pc    = ADDR_W'(a);
    e.instr = mem[a];
    sb.push_back(e);
  endtask

  // Waits (bounded) for an issue, then compares it with the oldest scoreboard entry.
  task automatic expect_issue(input string tag);
    int n = 0;
    exp_t e;
    logic [ADDR_W-1:0] link;
    while (!instr_valid && n < 30) begin
      tick();
      n++;
    end
    check({tag, " instr_valid"}, 64'(instr_valid), 64'(1));
    check({tag, " scoreboard entry"}, 64'(sb.size() > 0), 64'(1));
    if (sb.size() > 0) begin
      e    = sb.pop_front();
      link = e.pc + ADDR_W'(1);
      check({tag, " pc"}, 64'(pc), 64'(e.pc));
      check({tag, " instr"}, 64'(instr), 64'(e.instr));
      check({tag, " opcode"}, 64'(opcode), 64'(e.instr[31:26]));
      check({tag, " pc_plus1"}, 64'(pc_plus1), 64'(link));
    end
  endtask

  initial begin
    int rd_before;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0062_0020 | (32'(i) << 11);

    // Reset state
    tick();
    tick();
    check("rst pc", 64'(pc), 64'(0));
    check("rst imem_addr", 64'(imem_addr), 64'(0));
    check("rst instr", 64'(instr), 64'(0));
    check("rst instr_valid", 64'(instr_valid), 64'(0));
    check("rst imem_rd", 64'(imem_rd), 64'(0));
    check("rst halted", 64'(halted), 64'(0));
`ifdef FETCH_BOUNDS_EN
    check("rst fetch_fault", 64'(fetch_fault), 64'(0));
`endif

`ifndef FETCH_BOUNDS_EN
    // Sequential run, JUMP, JR and wrap at the top of the address space
    mem[5]     = {OP_JUMP, 16'h0, 10'h040};
    mem[10'h040] = {OP_JUMP, 16'h0, 10'h3FF};
    mem[10'h3FF] = {OP_JR, 26'h0};
    mem[10'h012] = {OP_JUMP, 16'h0, 10'h3FF};
    for (int i = 0; i <= 5; i++) push(i);
    push(10'h040); push(10'h3FF); push(10'h012); push(10'h3FF); push(0);
    resetCPU_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      expect_issue("seq");
      if (i > 0) check("seq issue spacing", 64'(cyc - last_issue), 64'(3));
      last_issue = cyc;
      tick();
    end
    expect_issue("seq pc4");
    tick();
    expect_issue("jump");
    check("jump link", 64'(pc_plus1), 64'(6));
    PCSource = PC_JUMP;
    tick();
    PCSource = PC_SEQ;
    check("jump fetch addr", 64'(imem_addr), 64'(10'h040));
    check("jump fetch rd", 64'(imem_rd), 64'(1));
    expect_issue("jump to top");
    PCSource = PC_JUMP;
    tick();
    PCSource = PC_SEQ;
    expect_issue("jr");
    jr_target = 10'h012;
    PCSource  = PC_JR;
    tick();
    PCSource  = PC_SEQ;
    jr_target = 10'h2AA;
    check("jr fetch addr", 64'(imem_addr), 64'(10'h012));
    expect_issue("jump back");
    PCSource = PC_JUMP;
    tick();
    PCSource = PC_SEQ;
    expect_issue("wrap src");
    tick();
    check("wrap fetch addr", 64'(imem_addr), 64'(0));
    check("wrap fetch rd", 64'(imem_rd), 64'(1));
    expect_issue("wrap");

    // Reset with a read outstanding, then a stray strobe after release
    tick();
    tick();
    check("wait imem_rd", 64'(imem_rd), 64'(0));
    resetCPU_n = 1'b0;
    #1;
    check("async rst pc", 64'(pc), 64'(0));
    check("async rst instr_valid", 64'(instr_valid), 64'(0));
    check("async rst instr", 64'(instr), 64'(0));
    tick();
    resetCPU_n  = 1'b1;
    inject_data = 32'hDEAD_BEEF;
    inject      = 1'b1;
    tick();
    inject = 1'b0;
    check("post rst imem_rd", 64'(imem_rd), 64'(1));
    check("post rst imem_addr", 64'(imem_addr), 64'(0));
    tick();
    check("stray data dropped", 64'(instr), 64'(0));
    push(0);
    expect_issue("post rst");
    mem[5] = 32'h0062_0020 | (32'd5 << 11);
`endif

    // HALT word under stall, with 2-cycle memory latency
    resetCPU_n = 1'b0;
    tick();
    lat    = 2;
    mem[7] = {OP_HALT, 26'h7};
    for (int i = 0; i <= 7; i++) push(i);
    resetCPU_n = 1'b1;
    for (int i = 0; i <= 7; i++) begin
      expect_issue("halt run");
      if (i == 1 || i == 2) check("lat2 issue spacing", 64'(cyc - last_issue), 64'(4));
      last_issue = cyc;
      if (i < 7) tick();
    end
    stall = 1'b1;
    tick();
    check("stall1 instr_valid", 64'(instr_valid), 64'(1));
    check("stall1 pc", 64'(pc), 64'(7));
    tick();
    check("stall2 instr_valid", 64'(instr_valid), 64'(1));
    check("stall2 halted", 64'(halted), 64'(0));
    stall = 1'b0;
    tick();
    check("halt halted", 64'(halted), 64'(1));
    check("halt instr_valid", 64'(instr_valid), 64'(0));
    rd_before = rd_count;
    repeat (10) tick();
    check("halt no reads", 64'(rd_count), 64'(rd_before));
    check("halt pc held", 64'(pc), 64'(7));
    check("halt opcode held", 64'(opcode), 64'(OP_HALT));
    check("halt sticky", 64'(halted), 64'(1));

`ifdef FETCH_BOUNDS_EN
    // Sequential run off the end of a 16-word memory
    resetCPU_n = 1'b0;
    tick();
    lat    = 1;
    mem[7] = 32'h0062_0020 | (32'd7 << 11);
    for (int i = 0; i < 16; i++) push(i);
    resetCPU_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      expect_issue("bounds run");
      tick();
    end
    rd_before = rd_count;
    check("bounds pc", 64'(pc), 64'(16));
    check("bounds no rd", 64'(imem_rd), 64'(0));
    tick();
    check("bounds fault", 64'(fetch_fault), 64'(1));
    check("bounds halted", 64'(halted), 64'(1));
    repeat (3) tick();
    check("bounds fault sticky", 64'(fetch_fault), 64'(1));
    check("bounds no reads", 64'(rd_count), 64'(rd_before));
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
